// File: rtl/spi_slave_word.sv
// Word-wide SPI slave with selectable mode, oversampled by clk, and a one-entry
// TX holding register. Received words leave as rx_data/rx_valid pulses.
module spi_slave_word #(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SCK,
    input  logic                        MOSI,
    output logic                        MISO,
    input  logic                        SSEL,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_underrun,
    output logic                        frame_end,
    output logic [$clog2(DATA_W)-1:0]   bit_count_out
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
    logic                   sck_d, ssel_d;
    logic                   sck_s, ssel_s, mosi_s;
    logic                   active, frame_start, frame_stop;
    logic                   sck_toggled, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, last_bit, load;
    logic [CNT_W-1:0]       bit_count;
    logic [DATA_W-1:0]      rx_shift, tx_shift, hold;
    logic                   full;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ssel_s = ssel_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronisers reset to the idle bus state so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            ssel_sync <= '1;
            mosi_sync <= '0;
            sck_d     <= CPOL;
            ssel_d    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d     <= sck_s;
            ssel_d    <= ssel_s;
        end
    end

    assign active      = ~ssel_s;
    assign frame_start = ssel_d & ~ssel_s;
    assign frame_stop  = ~ssel_d & ssel_s;
    assign sck_toggled = sck_s != sck_d;
    assign lead_edge   = sck_toggled && (sck_s != CPOL);
    assign trail_edge  = sck_toggled && (sck_s == CPOL);
    assign sample_edge = active && (CPHA ? trail_edge : lead_edge);
    assign shift_edge  = active && (CPHA ? lead_edge : trail_edge);
    assign last_bit    = bit_count == CNT_W'(DATA_W - 1);
    // With CPHA=0 the first word must be on MISO before the first sample edge.
    assign load        = (shift_edge && bit_count == '0) || (!CPHA && frame_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift  <= '0;
            bit_count <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            // NOTE: pulse outputs get their default first; a later non-blocking
            // assignment in the same block overrides it for this cycle.
            rx_valid  <= 1'b0;
            frame_end <= frame_stop;
            if (!active) begin
                bit_count <= '0;
                rx_shift  <= '0;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (last_bit) begin
                    bit_count <= '0;
                    rx_data   <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_valid  <= 1'b1;
                end else begin
                    bit_count <= bit_count + CNT_W'(1);
                end
            end
        end
    end

    // A load consumes the old holding content before a same-cycle handshake refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift    <= '0;
            hold        <= '0;
            full        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                if (full) begin
                    tx_shift <= hold;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_edge) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (tx_valid && !full) begin
                hold <= tx_data;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    assign tx_ready      = ~full;
    assign MISO          = tx_shift[DATA_W-1];
    assign bit_count_out = bit_count;

endmodule

// File: doc/spi_slave_word.md
Name: spi_slave_word

Overview:
- Parametrised SPI slave for the FPGA host link; next generation of the byte-wide SPI receiver/transmitter.
- Adds configurable word width, all four SPI modes, and a one-entry TX holding register with valid/ready handshake.
- Adds underrun and frame-end reporting, plus synchronous reset.
- Sits between the external SPI pins (oversampled by the system clock) and the command/register logic in the clk domain.

Parameters:
- DATA_W, 8, bits per SPI word, MSB first; legal range 2..32, any value (non-power-of-2 allowed).
- CPOL, 0, SCK idle level; 0 = idle low, 1 = idle high.
- CPHA, 0, 0 = sample MOSI on leading edge, shift MISO on trailing edge; 1 = shift MISO on leading edge, sample on trailing edge.
- SYNC_STAGES, 2, synchroniser depth for SCK, SSEL and MOSI; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst  in  1  synchronous active-high reset.
- SCK  in  1  SPI clock from master (asynchronous).
- MOSI  in  1  master-out data (asynchronous).
- MISO  out  1  slave-out data.
- SSEL  in  1  active-low chip select (asynchronous).
- rx_data  out  DATA_W  last fully received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  DATA_W  next word to send.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  holding register empty; a transfer occurs when tx_valid && tx_ready.
- tx_underrun  out  1  one-cycle pulse when a word load found the holding register empty.
- frame_end  out  1  one-cycle pulse on SSEL deassertion.
- bit_count_out  out  $clog2(DATA_W)  current bit index within the word.

Behaviour:
- Reset (synchronous, rst = 1 at a clk edge) clears the following:
  - synchronisers (SSEL synchroniser to 1, SCK synchroniser to CPOL);
  - shift registers and bit counter to 0;
  - rx_data = 0, holding register empty (tx_ready = 1);
  - rx_valid = tx_underrun = frame_end = 0, MISO = 0.
- Reset asserted mid-frame aborts the word. No rx_valid is produced for it, and a pending holding-register word is discarded.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, plus one flop for edge detect.
  - Leading edge = rising if CPOL = 0, falling if CPOL = 1. Trailing edge is the opposite.
  - sample_edge = leading if CPHA = 0, else trailing. shift_edge is the other one.
  - Frame active = synchronised SSEL low. frame_start = detected 1->0 transition of SSEL.
  - SCK edges are ignored while the frame is inactive.
- Receive:
  - On sample_edge: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}.
  - On the same sample_edge, bit_count increments and wraps DATA_W-1 -> 0 explicitly.
  - On the sample_edge where bit_count == DATA_W-1, the next clk writes rx_data with the completed word and pulses rx_valid for 1 cycle.
  - Consecutive words within one frame are supported without gaps.
  - rx_valid has no backpressure. The consumer must take rx_data before the next word completes.
- Frame inactive:
  - bit_count is held at 0 and the partial rx_shift is discarded; no rx_valid is issued.
  - frame_end pulses 1 cycle after the synchronised 0->1 transition of SSEL.
- Transmit:
  - MISO = tx_shift[DATA_W-1].
  - A word load occurs on:
    - shift_edge with bit_count == 0, or
    - frame_start when CPHA = 0, so the MSB is valid before the first sample edge.
  - For CPHA = 0, the shift_edge immediately following frame_start's load is the bit-1 shift. The load rule only triggers once bit_count has wrapped back to 0.
  - Load with holding register full: tx_shift <= holding and the holding register becomes empty.
  - Load with holding register empty: tx_shift <= 0 and tx_underrun pulses 1 cycle.
  - Otherwise, on shift_edge: tx_shift <= {tx_shift[DATA_W-2:0], 1'b0}.
- Holding register:
  - tx_ready = ~full.
  - When tx_valid && tx_ready, the holding register captures tx_data and becomes full next cycle.
  - A handshake and a load in the same cycle: the load consumes the old content (or underruns if empty), then the new word is captured. Net result is full.
- SSEL deasserted mid-word:
  - tx_shift holds its value and the holding register is kept.
  - The next frame_start (CPHA = 0) or first shift_edge (CPHA = 1) reloads from the holding register.

Test Plan:
- Mode 0, DATA_W=8: preload tx 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data = 0x3C with a single rx_valid pulse; tx_ready returns to 1 after the first load.
- Modes 1, 2 and 3, DATA_W=8: exchange 0x81 <-> 0x7E in each mode -> both directions bit-exact; rx_valid exactly once per word.
- DATA_W=12, mode 0, two back-to-back words 0xABC, 0x123 in one frame, second tx word offered mid-first-word -> rx_valid twice with 0xABC then 0x123; no underrun; bit_count_out wraps 11 -> 0.
- Empty holding register at frame start -> MISO all zeros for 8 bits, tx_underrun pulses once; master data still received correctly.
- SSEL released after 5 bits of 0xFF, then a full frame of 0x55 -> no rx_valid for the partial word; frame_end pulses once per release; next rx_data = 0x55.
- rst pulsed at bit 4 of a word with holding register full -> all outputs at reset values next cycle, tx_ready = 1; next frame underruns and receives correctly.
